tag_lookup_ctrl: RTL and testbench
==================================

Name: tag_lookup_ctrl

Overview:
- Sequencer for one direct-mapped cache tag RAM: a single-address, synchronous-read RAM with registered read address and rising-edge write.
- Accepts read/write lookups over a valid/ready handshake and drives the RAM address, write enable and data.
- Compares the stored tag, performs allocate or dirty-mark writes, and returns hit/miss and eviction info.
- After reset it clears the tag array before serving requests.

Parameters:
- AWIDTH, 3: tag RAM address width (index bits); DEPTH = 1<<AWIDTH.
- DWIDTH, 14: tag RAM word width. Entry layout: [DWIDTH-1] valid, [DWIDTH-2] dirty, [DWIDTH-3:0] tag.
- TWIDTH, derived localparam = DWIDTH-2: tag width.
- INIT_CLEAR, 1: 1 = sweep-write zero to all entries after reset; 0 = skip the sweep.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_addr  in  TWIDTH+AWIDTH  {tag, index}; index = req_addr[AWIDTH-1:0].
- req_write  in  1  1 = write lookup, 0 = read lookup.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_hit  out  1  stored entry valid and tag equal.
- rsp_evict  out  1  miss replaced a valid, dirty entry.
- rsp_evict_tag  out  TWIDTH  tag of the evicted entry.
- ram_addr  out  AWIDTH  registered RAM address.
- ram_din  out  DWIDTH  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_dout  in  DWIDTH  RAM read data, valid the cycle after the RAM samples ram_addr.

Behaviour:
- Reset (reset_n=0 at an edge): state goes to INIT (or IDLE if INIT_CLEAR=0). Outputs after that edge: req_ready=0, rsp_valid=0, rsp_hit=0, rsp_evict=0, rsp_evict_tag=0, ram_we=0, ram_addr=0, ram_din=0.
- Reset mid-operation: the in-flight request is discarded, no response is produced, and ram_we is 0 from the first reset edge on.
- INIT: ram_we=1, ram_din=0, ram_addr counts 0..DEPTH-1, one entry per cycle. After the DEPTH-1 write, go to IDLE. req_ready=0 throughout INIT.
- IDLE: req_ready=1. On req_valid&req_ready: capture tag, index and write flag; ram_addr<=index; go to LOOKUP.
- LOOKUP: one cycle; the RAM latches ram_addr. Go to COMPARE.
- COMPARE: ram_dout is valid.
  - hit = ram_dout[DWIDTH-1] & (ram_dout[TWIDTH-1:0]==tag).
  - Register rsp_hit. Register rsp_evict = ~hit & valid & dirty, with rsp_evict_tag = stored tag (0 when rsp_evict=0).
  - Read hit → RESP. All other cases → UPDATE.
- UPDATE: one cycle, ram_we=1, ram_addr=index.
  - write hit: ram_din = stored word | dirty bit.
  - read miss: ram_din = {1,0,tag}.
  - write miss: ram_din = {1,1,tag}.
  - Go to RESP.
- RESP: rsp_valid=1; rsp_* held stable until rsp_valid&rsp_ready, then go to IDLE. req_ready=0 throughout RESP; back-to-back acceptance is possible from the following IDLE cycle.
- Latency from the accepting edge: rsp_valid rises after the 3rd edge for a read hit, after the 4th edge otherwise.
- ram_we is only ever 1 in INIT and UPDATE. Only one request is outstanding at a time.
- req_addr and req_write are don't-care except at acceptance.
- Index 0 and index DEPTH-1 are handled identically to all others; there is no wrap condition beyond the INIT counter stopping at DEPTH-1.

Test Plan:
AWIDTH=3, DWIDTH=14, TWIDTH=12, INIT_CLEAR=1.
1. Reset release → ram_we=1 for exactly 8 cycles with ram_addr 0..7 and ram_din=0; req_ready=0 until the cycle after the addr-7 write.
2. Read req_addr={12'h0A5,3'd3} → rsp_hit=0, rsp_evict=0; UPDATE writes 14'h20A5 to entry 3; rsp_valid after the 4th edge.
3. Repeat the same read → rsp_hit=1, no ram_we pulse, rsp_valid after the 3rd edge.
4. Write {12'h0A5,3'd3} → hit, entry 3 becomes 14'h30A5. Then write {12'h1FF,3'd3} → rsp_hit=0, rsp_evict=1, rsp_evict_tag=12'h0A5, entry 3 becomes 14'h31FF.
5. Hold rsp_ready=0 for 5 cycles in RESP → rsp_* stable and req_ready=0. A new req_valid raised during RESP is accepted only after the response handshake.
6. Drive reset_n=0 during UPDATE of a write miss → ram_we=0 from the reset edge, no rsp_valid, and a full 8-entry INIT sweep follows release.

Source files
------------

// File: rtl/tag_lookup_ctrl.sv
// Sequencer for a direct-mapped cache tag RAM: clears the array after reset, then serves
// read/write lookups one at a time, doing allocate or dirty-mark writes as needed.
module tag_lookup_ctrl #(
  parameter int unsigned AWIDTH     = 3,
  parameter int unsigned DWIDTH     = 14,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [DWIDTH-2+AWIDTH-1:0] req_addr,
  input  logic                       req_write,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_hit,
  output logic                       rsp_evict,
  output logic [DWIDTH-3:0]          rsp_evict_tag,
  output logic [AWIDTH-1:0]          ram_addr,
  output logic [DWIDTH-1:0]          ram_din,
  output logic                       ram_we,
  input  logic [DWIDTH-1:0]          ram_dout
);

  localparam int unsigned TWIDTH = DWIDTH - 2;
  localparam logic [AWIDTH-1:0] LastIdx = {AWIDTH{1'b1}};
  localparam logic [DWIDTH-1:0] DirtyBit = {2'b01, {TWIDTH{1'b0}}};

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StLookup,
    StCompare,
    StUpdate,
    StResp
  } state_e;

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [TWIDTH-1:0]   tag_q, tag_d;
  logic                write_q, write_d;
  logic                we_q, we_d;
  logic [DWIDTH-1:0]   din_q, din_d;
  logic                ready_q, ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                hit_q, hit_d;
  logic                evict_q, evict_d;
  logic [TWIDTH-1:0]   etag_q, etag_d;

  logic stored_valid, stored_dirty, stored_hit;

  assign stored_valid = ram_dout[DWIDTH-1];
  assign stored_dirty = ram_dout[DWIDTH-2];
  assign stored_hit   = stored_valid && (ram_dout[TWIDTH-1:0] == tag_q);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    tag_d       = tag_q;
    write_d     = write_q;
    we_d        = 1'b0;
    din_d       = '0;
    ready_d     = 1'b0;
    rsp_valid_d = rsp_valid_q;
    hit_d       = hit_q;
    evict_d     = evict_q;
    etag_d      = etag_q;

    unique case (state_q)
      StInit: begin
        // First cycle out of reset only arms the sweep so ram_we stays low while reset is held.
        if (!we_q) begin
          we_d   = 1'b1;
          addr_d = '0;
        end else if (addr_q == LastIdx) begin
          state_d = StIdle;
          ready_d = 1'b1;
        end else begin
          we_d   = 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end
      StIdle: begin
        ready_d = 1'b1;
        if (req_valid && ready_q) begin
          ready_d = 1'b0;
          tag_d   = req_addr[AWIDTH +: TWIDTH];
          addr_d  = req_addr[AWIDTH-1:0];
          write_d = req_write;
          state_d = StLookup;
        end
      end
      StLookup: begin
        state_d = StCompare;
      end
      StCompare: begin
        hit_d   = stored_hit;
        evict_d = !stored_hit && stored_valid && stored_dirty;
        etag_d  = (!stored_hit && stored_valid && stored_dirty) ? ram_dout[TWIDTH-1:0] : '0;
        if (stored_hit && !write_q) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
        end else begin
          state_d = StUpdate;
          we_d    = 1'b1;
          din_d   = stored_hit ? (ram_dout | DirtyBit) : {1'b1, write_q, tag_q};
        end
      end
      StUpdate: begin
        state_d     = StResp;
        rsp_valid_d = 1'b1;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ready_d     = 1'b1;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= INIT_CLEAR ? StInit : StIdle;
      addr_q      <= '0;
      tag_q       <= '0;
      write_q     <= 1'b0;
      we_q        <= 1'b0;
      din_q       <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      evict_q     <= 1'b0;
      etag_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      tag_q       <= tag_d;
      write_q     <= write_d;
      we_q        <= we_d;
      din_q       <= din_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      hit_q       <= hit_d;
      evict_q     <= evict_d;
      etag_q      <= etag_d;
    end
  end

  assign req_ready     = ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_hit       = hit_q;
  assign rsp_evict     = evict_q;
  assign rsp_evict_tag = etag_q;
  assign ram_addr      = addr_q;
  assign ram_din       = din_q;
  assign ram_we        = we_q;

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Self-checking bench for tag_lookup_ctrl: bench-side tag RAM, an entry-level cache model,
// directed scenarios with literal expectations, and a randomized request stream.
module tb_tag_lookup_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [14:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_hit;
  logic        rsp_evict;
  logic [11:0] rsp_evict_tag;
  logic [2:0]  ram_addr;
  logic [13:0] ram_din;
  logic        ram_we;
  logic [13:0] ram_dout;

  tag_lookup_ctrl #(
    .AWIDTH    (3),
    .DWIDTH    (14),
    .INIT_CLEAR(1'b1)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_write    (req_write),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_hit      (rsp_hit),
    .rsp_evict    (rsp_evict),
    .rsp_evict_tag(rsp_evict_tag),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_we       (ram_we),
    .ram_dout     (ram_dout)
  );

  always #5 clock = ~clock;

  // Tag RAM: registered read address, read-old-data, rising-edge write. Starts with junk.
  logic [13:0] mem [8] = '{14'h3FFF, 14'h2ABC, 14'h3123, 14'h1555,
                           14'h3AAA, 14'h2F0F, 14'h3E01, 14'h37FF};
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // Model: expected RAM contents, expected write stream, expected response.
  logic [13:0] exp_mem [8];
  logic [16:0] exp_wr_q [$];
  logic        exp_hit, exp_evict;
  logic [11:0] exp_etag;
  bit          mon_en = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  logic        got_hit, got_evict;
  logic [11:0] got_etag;
  int          got_lat, got_we;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      if (ram_we === 1'b1) begin
        if (exp_wr_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", ram_addr,
                   ram_din);
        end else begin
          check("ram_write", {ram_addr, ram_din}, exp_wr_q.pop_front());
        end
      end
      if (rsp_valid === 1'b1) begin
        check("rsp_fields", {rsp_hit, rsp_evict, rsp_evict_tag}, {exp_hit, exp_evict, exp_etag});
        check("ready_in_resp", req_ready, 1'b0);
      end
    end
  end

  task automatic apply_reset(input int cycles);
    int n;
    int we_cnt;
    reset_n = 1'b0;
    step();
    mon_en = 1'b1;
    exp_wr_q.delete();
    for (int i = 0; i < 8; i++) begin
      exp_wr_q.push_back({3'(i), 14'h0});
      exp_mem[i] = 14'h0;
    end
    check("reset_outputs", {req_ready, rsp_valid, rsp_hit, rsp_evict, rsp_evict_tag, ram_we,
                            ram_addr, ram_din}, 64'h0);
    for (int c = 1; c < cycles; c++) begin
      step();
      check("reset_hold", {rsp_valid, ram_we, req_ready}, 3'b000);
    end
    reset_n = 1'b1;
    n = 0;
    we_cnt = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
      if (ram_we) we_cnt++;
    end
    check("init_cycles_to_ready", n, 9);
    check("init_write_cycles", we_cnt, 8);
    check("init_writes_left", exp_wr_q.size(), 0);
    for (int i = 0; i < 8; i++) check("init_cleared", mem[i], 14'h0);
  endtask

  task automatic do_req(input logic [11:0] tag, input logic [2:0] idx, input logic wr,
                        input int hold, input bit abort, input bit pre,
                        input logic [14:0] pre_addr, input logic pre_wr);
    int n;
    int edges;
    int exp_lat;
    logic [13:0] st;
    logic [13:0] newv;
    logic hit;
    n = 0;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    check("req_ready_wait", req_ready, 1'b1);
    st        = exp_mem[idx];
    hit       = st[13] && (st[11:0] == tag);
    exp_hit   = hit;
    exp_evict = !hit && st[13] && st[12];
    exp_etag  = exp_evict ? st[11:0] : 12'h0;
    exp_lat   = (hit && !wr) ? 3 : 4;
    if (!(hit && !wr)) begin
      newv = hit ? (st | 14'h1000) : {1'b1, wr, tag};
      exp_wr_q.push_back({idx, newv});
      exp_mem[idx] = newv;
    end
    req_valid = 1'b1;
    req_addr  = {tag, idx};
    req_write = wr;
    step();
    req_valid = 1'b0;
    req_addr  = 15'($urandom);
    req_write = 1'($urandom);
    edges = 1;
    got_we = 0;
    if (abort) begin
      step();
      step();
      check("we_in_update", ram_we, 1'b1);
      apply_reset(3);
      return;
    end
    while (!rsp_valid && edges < 12) begin
      step();
      edges++;
      if (ram_we) got_we++;
    end
    check("latency", edges, exp_lat);
    check("update_pulses", got_we, (hit && !wr) ? 0 : 1);
    got_lat   = edges;
    got_hit   = rsp_hit;
    got_evict = rsp_evict;
    got_etag  = rsp_evict_tag;
    for (int h = 0; h < hold; h++) begin
      if (pre) begin
        req_valid = 1'b1;
        req_addr  = pre_addr;
        req_write = pre_wr;
      end
      step();
      check("resp_held", {rsp_valid, req_ready}, 2'b10);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("resp_done", {rsp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] tag_pool [4];
    tag_pool = '{12'h0A5, 12'h1FF, 12'h3C3, 12'h800};

    apply_reset(2);

    // Read miss allocates a clean entry.
    do_req(12'h0A5, 3'd3, 1'b0, 0, 1'b0, 1'b0, 15'h0, 1'b0);
    check("t2_lat", got_lat, 4);
    check("t2_hit_evict", {got_hit, got_evict}, 2'b00);
    check("t2_entry", mem[3], 14'h20A5);

    // Same read hits without touching the RAM.
    do_req(12'h0A5, 3'd3, 1'b0, 0, 1'b0, 1'b0, 15'h0, 1'b0);
    check("t3_lat", got_lat, 3);
    check("t3_hit", got_hit, 1'b1);
    check("t3_no_write", got_we, 0);

    // Write hit marks dirty; write miss then evicts the dirty line.
    do_req(12'h0A5, 3'd3, 1'b1, 0, 1'b0, 1'b0, 15'h0, 1'b0);
    check("t4a_hit", got_hit, 1'b1);
    check("t4a_entry", mem[3], 14'h30A5);
    do_req(12'h1FF, 3'd3, 1'b1, 0, 1'b0, 1'b0, 15'h0, 1'b0);
    check("t4b_rsp", {got_hit, got_evict, got_etag}, {1'b0, 1'b1, 12'h0A5});
    check("t4b_entry", mem[3], 14'h31FF);

    // Back-pressured response with the next request already waiting.
    do_req(12'h022, 3'd5, 1'b0, 5, 1'b0, 1'b1, {12'h022, 3'd5}, 1'b0);
    check("t5a_entry", mem[5], 14'h2022);
    do_req(12'h022, 3'd5, 1'b0, 0, 1'b0, 1'b0, 15'h0, 1'b0);
    check("t5b_hit_lat", {got_hit, 4'(got_lat)}, {1'b1, 4'd3});

    // Boundary indices.
    do_req(12'hFFF, 3'd7, 1'b1, 1, 1'b0, 1'b0, 15'h0, 1'b0);
    check("idx7_entry", mem[7], 14'h3FFF);
    do_req(12'h000, 3'd0, 1'b0, 0, 1'b0, 1'b0, 15'h0, 1'b0);
    check("idx0_entry", mem[0], 14'h2000);

    // Reset during the UPDATE of a write miss.
    do_req(12'h777, 3'd6, 1'b1, 0, 1'b1, 1'b0, 15'h0, 1'b0);

    for (int k = 0; k < 200; k++) begin
      do_req(tag_pool[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 1'($urandom),
             $urandom_range(0, 2), 1'b0, 1'b0, 15'h0, 1'b0);
    end

    for (int i = 0; i < 8; i++) check("final_contents", mem[i], exp_mem[i]);
    check("final_writes_left", exp_wr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
